// File: rtl/game_fsm.sv
// Game phase sequencer: turns upstream commands into board-engine ops and tracks score/lines.
// Optional line-clear scoring is compiled in with GAME_FSM_SCORE_EN.

package enum_type;
   typedef enum logic [3:0] {
      NONE, INIT, WAIT, LEFT, RIGHT, DOWN, DROP, ROTATE, ROTATE_REV, HOLD, BAR, END
   } state_type;
endpackage

module game_fsm
   import enum_type::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  state_type   control,
   input  logic        start,
   input  logic        over,
   output state_type   state,
   output logic        op_valid,
   output logic [3:0]  op_code,
   input  logic        op_ready,
   input  logic        rsp_valid,
   input  logic        rsp_ok,
   input  logic [2:0]  rsp_lines,
   output logic [15:0] score,
   output logic [15:0] lines,
   output logic        hold_used,
   output logic        err
);

   localparam logic [3:0] OpLeft     = 4'd0;
   localparam logic [3:0] OpRight    = 4'd1;
   localparam logic [3:0] OpDown     = 4'd2;
   localparam logic [3:0] OpRot      = 4'd3;
   localparam logic [3:0] OpRotRev   = 4'd4;
   localparam logic [3:0] OpHoldSwap = 4'd5;
   localparam logic [3:0] OpBar      = 4'd6;
   localparam logic [3:0] OpLock     = 4'd7;
   localparam logic [3:0] OpSpawn    = 4'd8;
   localparam logic [3:0] OpClear    = 4'd9;

   // Position inside a phase; SubSpawn2 is the SPAWN that follows a board clear.
   typedef enum logic [2:0] {SubCmd, SubLock, SubSpawn, SubClr, SubSpawn2} sub_e;
   typedef enum logic [1:0] {HsIdle, HsReq, HsRsp} hs_e;

   state_type   state_q, state_d;
   sub_e        sub_q, sub_d;
   hs_e         hs_q, hs_d;
   logic [3:0]  op_code_q, op_code_d;
   logic [7:0]  tmo_q, tmo_d;
   logic [15:0] lines_q, lines_d;
   logic        hold_q, hold_d;
   logic        err_q, err_d;

   logic        wait_cyc, tmo_fire, got_rsp, done, ok;
   logic [2:0]  nlines;
   logic [16:0] lines_sum;

   function automatic logic [3:0] op_for(state_type c);
      case (c)
         LEFT:       return OpLeft;
         RIGHT:      return OpRight;
         ROTATE:     return OpRot;
         ROTATE_REV: return OpRotRev;
         BAR:        return OpBar;
         default:    return OpDown;
      endcase
   endfunction

   // A stalled handshake counts as a failed response once the counter wraps.
   assign wait_cyc  = (hs_q == HsReq && !op_ready) || (hs_q == HsRsp && !rsp_valid);
   assign tmo_fire  = wait_cyc && (tmo_q == 8'hFF);
   assign got_rsp   = (hs_q == HsRsp) && rsp_valid;
   assign done      = got_rsp || tmo_fire;
   assign ok        = got_rsp && rsp_ok;
   assign nlines    = !got_rsp ? 3'd0 : (rsp_lines > 3'd4) ? 3'd4 : rsp_lines;
   assign lines_sum = {1'b0, lines_q} + {14'd0, nlines};

`ifdef GAME_FSM_SCORE_EN
   logic [15:0] score_q, score_d;
   logic [3:0]  pts;
   logic [16:0] score_sum;

   always_comb begin
      pts = 4'd8;
      case (nlines)
         3'd0:    pts = 4'd0;
         3'd1:    pts = 4'd1;
         3'd2:    pts = 4'd3;
         3'd3:    pts = 4'd5;
         default: pts = 4'd8;
      endcase
   end

   assign score_sum = {1'b0, score_q} + {13'd0, pts};
   assign score     = score_q;
`else
   assign score = 16'd0;
`endif

   always_comb begin
      state_d   = state_q;
      sub_d     = sub_q;
      hs_d      = hs_q;
      op_code_d = op_code_q;
      tmo_d     = 8'd0;
      lines_d   = lines_q;
      hold_d    = hold_q;
      err_d     = err_q;
`ifdef GAME_FSM_SCORE_EN
      score_d   = score_q;
`endif

      if (tmo_fire) begin
         err_d = 1'b1;
      end else if (wait_cyc) begin
         tmo_d = tmo_q + 8'd1;
      end
      if (hs_q == HsReq && op_ready) hs_d = HsRsp;
      if (done) hs_d = HsIdle;

      case (state_q)
         NONE: begin
            if (start) begin
               state_d   = INIT;
               sub_d     = SubClr;
               hs_d      = HsReq;
               op_code_d = OpClear;
               lines_d   = 16'd0;
               hold_d    = 1'b0;
               err_d     = 1'b0;
`ifdef GAME_FSM_SCORE_EN
               score_d   = 16'd0;
`endif
            end
         end
         WAIT: begin
            if (control != NONE) begin
               sub_d = SubCmd;
               case (control)
                  LEFT, RIGHT, DOWN, DROP, ROTATE, ROTATE_REV, BAR: begin
                     state_d   = control;
                     hs_d      = HsReq;
                     op_code_d = op_for(control);
                  end
                  HOLD: begin
                     state_d = HOLD;
                     if (!hold_q) begin
                        hs_d      = HsReq;
                        op_code_d = OpHoldSwap;
                     end
                  end
                  default: state_d = END;
               endcase
            end
         end
         END: begin
            if (!over) state_d = WAIT;
         end
         default: begin
            // Idle handshake inside a phase only happens for a HOLD that was already used.
            if (hs_q == HsIdle) begin
               state_d = END;
            end else if (done) begin
               case (sub_q)
                  SubCmd: begin
                     case (state_q)
                        DOWN: begin
                           if (ok) begin
                              state_d = END;
                           end else begin
                              sub_d = SubLock; hs_d = HsReq; op_code_d = OpLock;
                           end
                        end
                        DROP: begin
                           hs_d = HsReq;
                           if (ok) begin
                              op_code_d = OpDown;
                           end else begin
                              sub_d = SubLock; op_code_d = OpLock;
                           end
                        end
                        HOLD: begin
                           if (ok) hold_d = 1'b1;
                           state_d = END;
                        end
                        BAR: begin
                           if (ok) begin
                              state_d = END;
                           end else begin
                              sub_d = SubClr; hs_d = HsReq; op_code_d = OpClear;
                           end
                        end
                        default: state_d = END;
                     endcase
                  end
                  SubLock: begin
                     lines_d   = lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
`ifdef GAME_FSM_SCORE_EN
                     score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
                     hold_d    = 1'b0;
                     sub_d     = SubSpawn;
                     hs_d      = HsReq;
                     op_code_d = OpSpawn;
                  end
                  SubSpawn: begin
                     if (ok) begin
                        state_d = END;
                     end else begin
                        sub_d = SubClr; hs_d = HsReq; op_code_d = OpClear;
                     end
                  end
                  SubClr: begin
                     sub_d     = SubSpawn2;
                     hs_d      = HsReq;
                     op_code_d = OpSpawn;
                  end
                  SubSpawn2: state_d = (state_q == INIT) ? WAIT : END;
                  default:   state_d = END;
               endcase
            end
         end
      endcase

      if (!start) begin
         state_d = NONE;
         hs_d    = HsIdle;
         tmo_d   = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= NONE;
         sub_q     <= SubCmd;
         hs_q      <= HsIdle;
         op_code_q <= 4'd0;
         tmo_q     <= 8'd0;
         lines_q   <= 16'd0;
         hold_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef GAME_FSM_SCORE_EN
         score_q   <= 16'd0;
`endif
      end else begin
         state_q   <= state_d;
         sub_q     <= sub_d;
         hs_q      <= hs_d;
         op_code_q <= op_code_d;
         tmo_q     <= tmo_d;
         lines_q   <= lines_d;
         hold_q    <= hold_d;
         err_q     <= err_d;
`ifdef GAME_FSM_SCORE_EN
         score_q   <= score_d;
`endif
      end
   end

   assign state     = state_q;
   assign op_valid  = (hs_q == HsReq);
   assign op_code   = op_code_q;
   assign lines     = lines_q;
   assign hold_used = hold_q;
   assign err       = err_q;

endmodule
